wptr_full_sync: RTL and testbench

Write-side pointer, full and fill-level logic for the dual-clock FIFO, living entirely in the write clock domain. It synchronizes the read domain's Gray read pointer through a 2-flop synchronizer and generates the memory write address and the Gray write pointer for the read domain. It also produces full and almost-full flags, a write-domain fill level and a sticky overflow flag. It is the write-domain counterpart of the read-pointer/empty block and connects to the same FIFO memory and pointer buses.

---
 rtl/wptr_full_sync.sv | 89 ++++++++
 tb/tb_wptr_full_sync.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_sync.sv
// Write-domain pointer, full/almost-full, fill level and sticky overflow for the dual-clock FIFO.
// The read pointer arrives as Gray code and is brought in through a two-flop synchronizer.
module wptr_full_sync #(
    parameter int ADDRSIZE    = 4,
    parameter int AFULL_LEVEL = (1 << ADDRSIZE) - 1
) (
    input  logic                wclk_i,
    input  logic                wrst_ni,
    input  logic                winc_i,
    input  logic                wovf_clr_i,
    input  logic [ADDRSIZE:0]   rptr_i,
    output logic [ADDRSIZE-1:0] waddr_o,
    output logic [ADDRSIZE:0]   wptr_o,
    output logic                wfull_o,
    output logic                w_almost_full_o,
    output logic [ADDRSIZE:0]   wlevel_o,
    output logic                woverflow_o
);

    localparam logic [ADDRSIZE:0] AFULL_THR = AFULL_LEVEL[ADDRSIZE:0];

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wptr;
    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] wq2_rbin;
    logic [ADDRSIZE:0] level_next;
    logic              wen;
    logic              full_val;
    logic              afull_val;
    logic              wfull;
    logic              wafull;
    logic              wovf;
    logic [ADDRSIZE:0] wlevel;

    always_ff @(posedge wclk_i or negedge wrst_ni) begin
        if (!wrst_ni) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr_i;
            wq2_rptr <= wq1_rptr;
        end
    end

    assign wen       = winc_i & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    always_comb begin
        wq2_rbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wq2_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign full_val   = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
    assign level_next = wbinnext - wq2_rbin;
    assign afull_val  = (level_next >= AFULL_THR);

    always_ff @(posedge wclk_i or negedge wrst_ni) begin
        if (!wrst_ni) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
            wovf   <= 1'b0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= full_val;
            wafull <= afull_val;
            wlevel <= level_next;
            wovf   <= (winc_i & wfull) | (wovf & ~wovf_clr_i);
        end
    end

    assign waddr_o         = wbin[ADDRSIZE-1:0];
    assign wptr_o          = wptr;
    assign wfull_o         = wfull;
    assign w_almost_full_o = wafull;
    assign wlevel_o        = wlevel;
    assign woverflow_o     = wovf;

endmodule

// File: tb/tb_wptr_full_sync.sv
// Bench for wptr_full_sync: directed scenarios plus a random run against a count-based FIFO model.
// The model tracks unbounded write/read counts and derives every expected output from them.
module tb_wptr_full_sync;

    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;
    localparam int AFULL    = DEPTH - 1;

    logic                wclk = 1'b0;
    logic                wrst_n = 1'b0;
    logic                winc = 1'b0;
    logic                clr = 1'b0;
    logic [ADDRSIZE:0]   rptr = '0;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wlevel;
    logic                wovf;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: total writes accepted, read count driven, and the read count as seen two edges late.
    int   m_wr, rd_cnt, m_s1, m_s2, m_level;
    logic m_full, m_afull, m_ovf;

    wptr_full_sync #(.ADDRSIZE(ADDRSIZE), .AFULL_LEVEL(AFULL)) dut (
        .wclk_i          (wclk),
        .wrst_ni         (wrst_n),
        .winc_i          (winc),
        .wovf_clr_i      (clr),
        .rptr_i          (rptr),
        .waddr_o         (waddr),
        .wptr_o          (wptr),
        .wfull_o         (wfull),
        .w_almost_full_o (wafull),
        .wlevel_o        (wlevel),
        .woverflow_o     (wovf)
    );

    always #5 wclk = ~wclk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDRSIZE:0] gray(input int v);
        logic [ADDRSIZE:0] b;
        b = (ADDRSIZE+1)'(v % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic model_clear();
        m_wr = 0; m_s1 = 0; m_s2 = 0; m_level = 0;
        m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic set_rd(input int n);
        rd_cnt = n;
        rptr   = gray(n);
    endtask

    // One write-clock edge; the model advances with the inputs present at that edge.
    task automatic tick();
        logic acc, ovf_n;
        @(posedge wclk);
        if (!wrst_n) begin
            model_clear();
        end else begin
            acc     = winc && !m_full;
            ovf_n   = (winc && m_full) || (m_ovf && !clr);
            m_wr    = m_wr + int'(acc);
            m_level = m_wr - m_s2;
            m_full  = (m_level == DEPTH);
            m_afull = (m_level >= AFULL);
            m_ovf   = ovf_n;
            m_s2    = m_s1;
            m_s1    = rd_cnt;
        end
        #1;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0; winc = 1'b0; clr = 1'b0;
        set_rd(0);
        model_clear();
        tick();
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            winc = 1'($urandom); clr = 1'($urandom); rptr = 5'($urandom);
            tick();
            n_cmp++;
            if ({waddr, wptr, wfull, wafull, wlevel, wovf} !== '0) begin
                n_err++;
                $display("FAIL reset_hold: got waddr=%0d wptr=%b full=%b afull=%b level=%0d ovf=%b, required all 0",
                         waddr, wptr, wfull, wafull, wlevel, wovf);
            end
        end
        winc = 1'b0; clr = 1'b0; set_rd(0);
        model_clear();
        wrst_n = 1'b1;
        winc = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        winc = 1'b0;
        n_cmp++;
        if (wlevel !== 5'd5) begin
            n_err++;
            $display("FAIL reset_prefill: got level=%0d required 5", wlevel);
        end
        #2 wrst_n = 1'b0;
        #1;
        n_cmp++;
        if ({waddr, wptr, wlevel} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got waddr=%0d wptr=%b level=%0d required 0 before any edge",
                     waddr, wptr, wlevel);
        end
        model_clear();
        tick();
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                n_cmp++;
                if (wafull !== 1'b1 || wlevel !== 5'd15 || wfull !== 1'b0) begin
                    n_err++;
                    $display("FAIL fill_15: got afull=%b level=%0d full=%b required 1/15/0", wafull, wlevel, wfull);
                end
            end
        end
        n_cmp++;
        if (wfull !== 1'b1 || wlevel !== 5'd16 || waddr !== 4'd0 || wptr !== 5'b11000) begin
            n_err++;
            $display("FAIL fill_16: got full=%b level=%0d waddr=%0d wptr=%b required 1/16/0/11000",
                     wfull, wlevel, waddr, wptr);
        end
    endtask

    task automatic test_overflow();
        tick();
        n_cmp++;
        if (wptr !== 5'b11000 || waddr !== 4'd0 || wovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: got wptr=%b waddr=%0d ovf=%b required 11000/0/1", wptr, waddr, wovf);
        end
        winc = 1'b0; clr = 1'b1;
        tick();
        n_cmp++;
        if (wovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: got ovf=%b required 0", wovf);
        end
        winc = 1'b1; clr = 1'b1;
        tick();
        n_cmp++;
        if (wovf !== 1'b1 || wfull !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_priority: got ovf=%b full=%b required 1/1", wovf, wfull);
        end
        winc = 1'b0; clr = 1'b0;
    endtask

    task automatic test_drain();
        for (int e = 1; e <= 6; e++) begin
            if (e <= 4) set_rd(e);
            tick();
            n_cmp++;
            if (wfull !== (e < 3)) begin
                n_err++;
                $display("FAIL drain_full edge=%0d: got full=%b required %b", e, wfull, (e < 3));
            end
        end
        n_cmp++;
        if (wlevel !== 5'd12 || rptr !== 5'b00110) begin
            n_err++;
            $display("FAIL drain_level: got level=%0d required 12", wlevel);
        end
    endtask

    task automatic test_wrap();
        bit seen_zero = 0;
        do_reset();
        winc = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            set_rd((m_wr > 4) ? m_wr - 4 : 0);
            n_cmp++;
            if (wlevel > 5'd16 || wfull !== 1'b0 || wlevel !== 5'(m_level)) begin
                n_err++;
                $display("FAIL wrap_level i=%0d: got level=%0d full=%b required level=%0d full=0",
                         i, wlevel, wfull, m_level);
            end
            if (i == 32) begin
                seen_zero = 1;
                n_cmp++;
                if (wptr !== 5'd0 || waddr !== 4'd0) begin
                    n_err++;
                    $display("FAIL wrap_32: got wptr=%b waddr=%0d required 0/0", wptr, waddr);
                end
            end
        end
        winc = 1'b0;
        n_cmp++;
        if (wptr !== 5'b01100 || !seen_zero) begin
            n_err++;
            $display("FAIL wrap_40: got wptr=%b required 01100", wptr);
        end
    endtask

    task automatic test_random();
        int rd_pct;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            rd_pct = ((i / 100) % 2 == 0) ? 20 : 70;
            winc = ($urandom_range(0, 99) < 65);
            clr  = ($urandom_range(0, 99) < 10);
            if (rd_cnt < m_wr && $urandom_range(0, 99) < rd_pct) set_rd(rd_cnt + 1);
            tick();
            n_cmp++;
            if (wfull !== m_full || wafull !== m_afull || wovf !== m_ovf) begin
                n_err++;
                $display("FAIL rnd_flags cyc=%0d: got full=%b afull=%b ovf=%b required %b/%b/%b",
                         i, wfull, wafull, wovf, m_full, m_afull, m_ovf);
            end
            n_cmp++;
            if (wlevel !== 5'(m_level) || waddr !== 4'(m_wr % DEPTH) || wptr !== gray(m_wr)) begin
                n_err++;
                $display("FAIL rnd_ptr cyc=%0d: got level=%0d waddr=%0d wptr=%b required %0d/%0d/%b",
                         i, wlevel, waddr, wptr, m_level, m_wr % DEPTH, gray(m_wr));
            end
            n_cmp++;
            if (wfull !== (wlevel == 5'd16)) begin
                n_err++;
                $display("FAIL rnd_invariant cyc=%0d: got full=%b level=%0d", i, wfull, wlevel);
            end
        end
        winc = 1'b0; clr = 1'b0;
    endtask

    initial begin
        rd_cnt = 0;
        model_clear();
        test_reset();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
